// File: rtl/scfifo_mw.sv
// rtl/scfifo_mw.sv - single-clock FIFO with mixed write/read word widths.
// Storage is kept in NW-bit slices; write and read ports pack/unpack whole words.
module scfifo_mw #(
    parameter int    WWIDTH    = 32,
    parameter int    RWIDTH    = 8,
    parameter int    DEPTH     = 64,
    parameter string ORDER     = "LSB",
    parameter string PROTECTED = "Y",
    parameter int    AFULL     = DEPTH - 8,
    parameter int    AEMPTY    = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic [WWIDTH-1:0]        data,
    input  logic                     write,
    input  logic                     read,
    output logic [RWIDTH-1:0]        q,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   usedw,
    output logic [$clog2(DEPTH):0]   usedr,
    output logic                     ovf,
    output logic                     unf
);

    localparam int NW = (WWIDTH < RWIDTH) ? WWIDTH : RWIDTH;
    localparam int MX = (WWIDTH < RWIDTH) ? RWIDTH : WWIDTH;
    localparam int WU = WWIDTH / NW;
    localparam int RU = RWIDTH / NW;
    localparam int AW = $clog2(DEPTH);
    localparam int MU = (WU > RU) ? WU : RU;

    localparam bit MSB_FIRST = (ORDER == "MSB");
    localparam bit PROT      = (PROTECTED == "Y");

    localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);
    localparam logic [AW:0] WU_N    = (AW+1)'(WU);
    localparam logic [AW:0] RU_N    = (AW+1)'(RU);
    localparam logic [AW:0] AF_N    = (AW+1)'(AFULL);
    localparam logic [AW:0] AE_N    = (AW+1)'(AEMPTY);

    if (MX % NW != 0) begin : g_bad_width
        $error("scfifo_mw: max(WWIDTH,RWIDTH) must be a multiple of min(WWIDTH,RWIDTH)");
    end
    if (DEPTH < 16 || (DEPTH & (DEPTH - 1)) != 0 || DEPTH < 2 * MU) begin : g_bad_depth
        $error("scfifo_mw: DEPTH must be a power of 2, >= 16 and >= 2*max(WU,RU)");
    end

    logic [NW-1:0]     mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [AW:0]       cnt;
    logic [RWIDTH-1:0] rd_word;
    logic              wr_ok;
    logic              rd_ok;

    assign full         = (DEPTH_N - cnt) < WU_N;
    assign empty        = cnt < RU_N;
    assign almost_full  = cnt >= AF_N;
    assign almost_empty = cnt <= AE_N;
    assign usedw        = cnt / WU_N;
    assign usedr        = cnt / RU_N;

    assign wr_ok = write && !flush && !(PROT && full);
    assign rd_ok = read  && !flush && !(PROT && empty);

    // Memory has no reset; occupancy and pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int i = 0; i < WU; i++) begin
                if (MSB_FIRST)
                    mem[wptr + AW'(i)] <= data[(WU-1-i)*NW +: NW];
                else
                    mem[wptr + AW'(i)] <= data[i*NW +: NW];
            end
        end
    end

    always_comb begin
        rd_word = '0;
        for (int j = 0; j < RU; j++) begin
            if (MSB_FIRST)
                rd_word[(RU-1-j)*NW +: NW] = mem[rptr + AW'(j)];
            else
                rd_word[j*NW +: NW] = mem[rptr + AW'(j)];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt  <= '0;
            wptr <= '0;
            rptr <= '0;
            q    <= '0;
            ovf  <= 1'b0;
            unf  <= 1'b0;
        end else begin
            ovf <= PROT && write && !flush && full;
            unf <= PROT && read  && !flush && empty;
            if (flush) begin
                cnt  <= '0;
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (wr_ok)
                    wptr <= wptr + AW'(WU);
                if (rd_ok) begin
                    rptr <= rptr + AW'(RU);
                    q    <= rd_word;
                end
                cnt <= cnt + (wr_ok ? WU_N : '0) - (rd_ok ? RU_N : '0);
            end
        end
    end

endmodule

// File: tb/tb_scfifo_mw.sv
// tb/tb_scfifo_mw.sv - directed self-checking bench for scfifo_mw.
// u_a/u_b: 32->8 LSB/MSB sharing stimulus; u_c: 8->32 LSB.
module tb_scfifo_mw;

    logic        clk;
    logic        rstn;
    logic        flush;
    logic [31:0] ab_data;
    logic        ab_wr;
    logic        ab_rd;
    logic [7:0]  c_data;
    logic        c_wr;
    logic        c_rd;

    logic [7:0]  a_q, b_q;
    logic        a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    logic        b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
    logic [6:0]  a_usedw, a_usedr, b_usedw, b_usedr;
    logic [31:0] c_q;
    logic        c_full, c_empty, c_af, c_ae, c_ovf, c_unf;
    logic [6:0]  c_usedw, c_usedr;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q [$];
    logic [7:0] last_q;
    logic [7:0] nb;
    logic [7:0] lsb_seq [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic [7:0] msb_seq [4] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};

    scfifo_mw #(.WWIDTH(32), .RWIDTH(8), .DEPTH(64), .ORDER("LSB")) u_a (
        .clk(clk), .rstn(rstn), .flush(flush), .data(ab_data), .write(ab_wr), .read(ab_rd),
        .q(a_q), .full(a_full), .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae),
        .usedw(a_usedw), .usedr(a_usedr), .ovf(a_ovf), .unf(a_unf));

    scfifo_mw #(.WWIDTH(32), .RWIDTH(8), .DEPTH(64), .ORDER("MSB")) u_b (
        .clk(clk), .rstn(rstn), .flush(flush), .data(ab_data), .write(ab_wr), .read(ab_rd),
        .q(b_q), .full(b_full), .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
        .usedw(b_usedw), .usedr(b_usedr), .ovf(b_ovf), .unf(b_unf));

    scfifo_mw #(.WWIDTH(8), .RWIDTH(32), .DEPTH(64), .ORDER("LSB")) u_c (
        .clk(clk), .rstn(rstn), .flush(flush), .data(c_data), .write(c_wr), .read(c_rd),
        .q(c_q), .full(c_full), .empty(c_empty), .almost_full(c_af), .almost_empty(c_ae),
        .usedw(c_usedw), .usedr(c_usedr), .ovf(c_ovf), .unf(c_unf));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mkw(input logic [7:0] b);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    task automatic push_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) exp_q.push_back(w[k*8 +: 8]);
    endtask

    task automatic read_check(input int n, input string tag);
        logic [7:0] e;
        ab_rd = 1'b1;
        for (int k = 0; k < n; k++) begin
            tick;
            e = exp_q.pop_front();
            last_q = e;
            check(tag, a_q, e);
        end
        ab_rd = 1'b0;
    endtask

    initial begin
        rstn = 1'b1; flush = 1'b0;
        ab_data = '0; ab_wr = 1'b0; ab_rd = 1'b0;
        c_data = '0; c_wr = 1'b0; c_rd = 1'b0;
        last_q = '0;
        #1 rstn = 1'b0;
        #2;
        check("rst_empty", a_empty, 1);
        check("rst_full", a_full, 0);
        check("rst_ae", a_ae, 1);
        check("rst_af", a_af, 0);
        check("rst_usedw", a_usedw, 0);
        check("rst_usedr", a_usedr, 0);
        check("rst_q", a_q, 0);
        check("rst_ovf_unf", {a_ovf, a_unf}, 0);
        check("rst_c_empty", c_empty, 1);
        rstn = 1'b1;
        tick;

        // one 32-bit word unpacked as bytes, both orders
        ab_data = 32'hDDCCBBAA; ab_wr = 1'b1;
        tick;
        ab_wr = 1'b0;
        check("w1_usedr", a_usedr, 4);
        check("w1_usedw", a_usedw, 1);
        ab_rd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("lsb_q", a_q, lsb_seq[i]);
            check("msb_q", b_q, msb_seq[i]);
        end
        ab_rd = 1'b0;
        check("lsb_empty", a_empty, 1);
        check("msb_empty", b_empty, 1);

        // bytes packed into 32-bit word
        for (int i = 0; i < 3; i++) begin
            c_data = 8'(8'h11 * (i + 1)); c_wr = 1'b1;
            tick;
            check("pack_empty", c_empty, 1);
            check("pack_usedr0", c_usedr, 0);
        end
        c_data = 8'h44;
        tick;
        c_wr = 1'b0;
        check("pack_empty4", c_empty, 0);
        check("pack_usedr1", c_usedr, 1);
        check("pack_usedw4", c_usedw, 4);
        c_rd = 1'b1;
        tick;
        c_rd = 1'b0;
        check("pack_q", c_q, 32'h44332211);
        check("pack_empty_after", c_empty, 1);

        // fill to capacity, then overflow and underflow
        nb = 8'd0;
        ab_wr = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ab_data = mkw(nb);
            tick;
            push_word(mkw(nb));
            nb = nb + 8'd4;
            if (i == 12) check("af_52", a_af, 0);
            if (i == 13) check("af_56", a_af, 1);
        end
        ab_wr = 1'b0;
        check("full", a_full, 1);
        check("full_usedw", a_usedw, 16);
        check("full_usedr", a_usedr, 64);
        check("full_af", a_af, 1);
        ab_data = 32'hFFFFFFFF; ab_wr = 1'b1;
        tick;
        ab_wr = 1'b0;
        check("ovf_pulse", a_ovf, 1);
        check("ovf_usedr", a_usedr, 64);
        tick;
        check("ovf_clear", a_ovf, 0);

        read_check(32, "drain32_q");
        check("n32", a_usedr, 32);

        // concurrent write+read: +3 units per cycle
        ab_wr = 1'b1; ab_rd = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ab_data = mkw(nb);
            tick;
            last_q = exp_q.pop_front();
            check("wr_rd_q", a_q, last_q);
            push_word(mkw(nb));
            nb = nb + 8'd4;
        end
        ab_wr = 1'b0; ab_rd = 1'b0;
        check("n62", a_usedr, 62);
        check("n62_full", a_full, 1);
        check("n62_usedw", a_usedw, 15);

        read_check(62, "drain62_q");
        check("drained_empty", a_empty, 1);
        check("drained_ae", a_ae, 1);
        ab_rd = 1'b1;
        tick;
        ab_rd = 1'b0;
        check("unf_pulse", a_unf, 1);
        check("unf_usedr", a_usedr, 0);
        tick;
        check("unf_clear", a_unf, 0);

        // flush at N=20 with a concurrent write
        ab_wr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ab_data = mkw(nb);
            tick;
            nb = nb + 8'd4;
        end
        check("n20", a_usedr, 20);
        check("n20_ae", a_ae, 0);
        flush = 1'b1; ab_data = mkw(nb);
        tick;
        flush = 1'b0; ab_wr = 1'b0;
        check("flush_usedr", a_usedr, 0);
        check("flush_empty", a_empty, 1);
        check("flush_ovf", a_ovf, 0);
        check("flush_q_hold", a_q, last_q);
        exp_q.delete();

        // asynchronous reset mid-stream
        nb = 8'hA0;
        ab_wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ab_data = mkw(nb);
            tick;
            push_word(mkw(nb));
            nb = nb + 8'd4;
        end
        ab_wr = 1'b0;
        read_check(1, "pre_rst_q");
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check("arst_q", a_q, 0);
        check("arst_empty", a_empty, 1);
        check("arst_full", a_full, 0);
        check("arst_usedr", a_usedr, 0);
        check("arst_usedw", a_usedw, 0);
        check("arst_ae_af", {a_ae, a_af}, 2'b10);
        check("arst_ovf_unf", {a_ovf, a_unf}, 0);
        #3 rstn = 1'b1;
        exp_q.delete();
        tick;
        ab_data = mkw(8'h50); ab_wr = 1'b1;
        tick;
        ab_wr = 1'b0;
        push_word(mkw(8'h50));
        read_check(1, "post_rst_q");
        check("post_rst_usedr", a_usedr, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
